// File: rtl/imm_pkg.sv
// Shared constants for the decode-stage immediate generator: format selects, RV opcodes and
// the XLEN legality check.
package imm_pkg;

  localparam logic [2:0] IMM_SEL_I   = 3'b000;
  localparam logic [2:0] IMM_SEL_S   = 3'b001;
  localparam logic [2:0] IMM_SEL_B   = 3'b010;
  localparam logic [2:0] IMM_SEL_U   = 3'b011;
  localparam logic [2:0] IMM_SEL_J   = 3'b100;
  localparam logic [2:0] IMM_SEL_Z   = 3'b101;
  localparam logic [2:0] IMM_SEL_ILL = 3'b110;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

endpackage

// File: rtl/imm_extract.sv
// Combinational immediate extraction and sign extension for all RV immediate formats.
// IMM_AUTO_DECODE_EN: derive the format from the opcode instead of sel.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      sel,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);

  logic [2:0]  fmt;
  logic [31:0] imm32;

`ifdef IMM_AUTO_DECODE_EN
  logic unused_sel;
  assign unused_sel = ^sel;

  always_comb begin
    fmt = IMM_SEL_ILL;
    case (instr[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: fmt = IMM_SEL_I;
      OPC_SYSTEM:          fmt = instr[14] ? IMM_SEL_Z : IMM_SEL_I;
      OPC_STORE:           fmt = IMM_SEL_S;
      OPC_BRANCH:          fmt = IMM_SEL_B;
      OPC_LUI, OPC_AUIPC:  fmt = IMM_SEL_U;
      OPC_JAL:             fmt = IMM_SEL_J;
      default:             fmt = IMM_SEL_ILL;
    endcase
  end
`else
  assign fmt = sel;
`endif

  // Every format is first formed as a 32-bit value already extended from its own MSB.
  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (fmt)
      IMM_SEL_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_SEL_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_SEL_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_SEL_U: imm32 = {instr[31:12], 12'b0};
      IMM_SEL_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21],
                          1'b0};
      IMM_SEL_Z: imm32 = {27'b0, instr[19:15]};
      default:   illegal = 1'b1;
    endcase
  end

  // Z has bit 31 clear, so widening by bit 31 is correct for all formats.
  if (XLEN > 32) begin : g_wide
    assign imm = {{(XLEN-32){imm32[31]}}, imm32};
  end else begin : g_narrow
    assign imm = imm32[XLEN-1:0];
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with valid/ready handshake and a one-entry skid buffer.
// IMM_AUTO_DECODE_EN (in imm_extract) selects opcode-driven format decoding.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_imm_sel,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } entry_t;

  entry_t or_q, or_d, sk_q, sk_d, in_entry;
  logic [XLEN-1:0] ext_imm;
  logic            ext_illegal;
  logic            or_load;
  logic            in_fire;

  imm_extract #(
    .XLEN(XLEN)
  ) u_extract (
    .instr  (in_instr),
    .sel    (in_imm_sel),
    .imm    (ext_imm),
    .illegal(ext_illegal)
  );

  assign in_entry = '{valid: 1'b1, imm: ext_imm, tag: in_tag, illegal: ext_illegal};
  assign or_load  = !or_q.valid || out_ready;
  assign in_fire  = in_valid && !sk_q.valid;

  // in_ready is low whenever SK is valid, so SK->OR and input capture never coincide.
  always_comb begin
    or_d = or_q;
    sk_d = sk_q;
    if (flush) begin
      or_d.valid = 1'b0;
      sk_d.valid = 1'b0;
    end else if (or_load) begin
      if (sk_q.valid) begin
        or_d       = sk_q;
        sk_d.valid = 1'b0;
      end else if (in_fire) begin
        or_d = in_entry;
      end else begin
        or_d.valid = 1'b0;
      end
    end else if (in_fire) begin
      sk_d = in_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      or_q <= '0;
      sk_q <= '0;
    end else begin
      or_q <= or_d;
      sk_q <= sk_d;
    end
  end

  assign in_ready    = !sk_q.valid;
  assign out_valid   = or_q.valid;
  assign out_imm     = or_q.imm;
  assign out_tag     = or_q.tag;
  assign out_illegal = or_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are
// compared against a queue-based reference model.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr, in_tag;
  logic [2:0]  in_imm_sel;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32, out_tag32;
  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [31:0] out_tag64;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(out_valid32),
    .out_ready(out_ready), .out_imm(out_imm32), .out_tag(out_tag32),
    .out_illegal(out_illegal32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_imm_sel(in_imm_sel), .in_tag(in_tag), .out_valid(out_valid64),
    .out_ready(out_ready), .out_imm(out_imm64), .out_tag(out_tag64),
    .out_illegal(out_illegal64)
  );

  typedef struct {
    logic [63:0] imm;
    logic [31:0] tag;
    bit          ill;
  } ent_t;

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  sel;
    logic [31:0] tag;
    logic [63:0] imm;
    bit          ill;
  } vec_t;

  localparam int NV = 10;
  vec_t        vt[NV];
  ent_t        q[$];
  logic [31:0] seen[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: immediates built as signed values of their natural width, then widened.
  function automatic void model(input logic [31:0] ins, input logic [2:0] sel,
                                output logic [63:0] imm, output bit ill);
    int fmt;
    imm = '0;
    ill = 1'b0;
`ifdef IMM_AUTO_DECODE_EN
    case (ins[6:0])
      7'h03, 7'h13, 7'h67, 7'h0F: fmt = 0;
      7'h73:        fmt = ins[14] ? 5 : 0;
      7'h23:        fmt = 1;
      7'h63:        fmt = 2;
      7'h37, 7'h17: fmt = 3;
      7'h6F:        fmt = 4;
      default:      fmt = 6;
    endcase
`else
    fmt = int'(sel);
`endif
    case (fmt)
      0: imm = longint'($signed(ins[31:20]));
      1: imm = longint'($signed({ins[31:25], ins[11:7]}));
      2: imm = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      3: imm = longint'($signed({ins[31:12], 12'b0}));
      4: imm = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      5: imm = 64'(ins[19:15]);
      default: ill = 1'b1;
    endcase
  endfunction

  // One clock: drive at negedge, check registered outputs against the model, then advance it.
  task automatic cycle(input bit iv, input logic [31:0] ins, input logic [2:0] sel,
                       input logic [31:0] tag, input bit ordy, input bit fl, input bit rs);
    ent_t e;
    bit   exp_ready;
    @(negedge clk);
    in_valid = iv; in_instr = ins; in_imm_sel = sel; in_tag = tag;
    out_ready = ordy; flush = fl; rst = rs;
    #1;
    exp_ready = q.size() < 2;
    check("out_valid32", 64'(out_valid32), 64'(q.size() > 0));
    check("out_valid64", 64'(out_valid64), 64'(q.size() > 0));
    check("in_ready32", 64'(in_ready32), 64'(exp_ready));
    check("in_ready64", 64'(in_ready64), 64'(exp_ready));
    if (q.size() > 0) begin
      check("out_imm32", 64'(out_imm32), {32'b0, q[0].imm[31:0]});
      check("out_imm64", out_imm64, q[0].imm);
      check("out_tag32", 64'(out_tag32), 64'(q[0].tag));
      check("out_tag64", 64'(out_tag64), 64'(q[0].tag));
      check("out_illegal32", 64'(out_illegal32), 64'(q[0].ill));
      check("out_illegal64", 64'(out_illegal64), 64'(q[0].ill));
    end
    if (out_valid32 && ordy) seen.push_back(out_tag32);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (ordy && q.size() > 0) void'(q.pop_front());
      if (iv && exp_ready) begin
        model(ins, sel, e.imm, e.ill);
        e.tag = tag;
        q.push_back(e);
      end
    end
  endtask

  task automatic check_vec(input string name, input vec_t v);
    check({name, "_imm32"}, 64'(out_imm32), {32'b0, v.imm[31:0]});
    check({name, "_imm64"}, out_imm64, v.imm);
    check({name, "_tag"}, 64'(out_tag32), 64'(v.tag));
    check({name, "_ill"}, 64'(out_illegal64), 64'(v.ill));
  endtask

  task automatic check_empty_reset(input string name);
    check({name, "_valid"}, 64'(out_valid32 | out_valid64), 64'(0));
    check({name, "_ready"}, 64'(in_ready32 & in_ready64), 64'(1));
    check({name, "_imm32"}, 64'(out_imm32), 64'(0));
    check({name, "_imm64"}, out_imm64, 64'(0));
    check({name, "_tag"}, 64'(out_tag32 | out_tag64), 64'(0));
    check({name, "_ill"}, 64'(out_illegal32 | out_illegal64), 64'(0));
  endtask

  initial begin
    vt[0] = '{32'hFFC12083, 3'b000, 32'h0000_0011, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vt[1] = '{32'h00512423, 3'b001, 32'h0000_0022, 64'h00000000_00000008, 1'b0};
    vt[2] = '{32'hFE000CE3, 3'b010, 32'hDEAD_BEEF, 64'hFFFFFFFF_FFFFFFF8, 1'b0};
    vt[3] = '{32'hFFDFF06F, 3'b100, 32'h0000_0044, 64'hFFFFFFFF_FFFFFFFC, 1'b0};
    vt[4] = '{32'h123450B7, 3'b011, 32'h0000_0055, 64'h00000000_12345000, 1'b0};
    vt[5] = '{32'h800000B7, 3'b011, 32'h0000_0066, 64'hFFFFFFFF_80000000, 1'b0};
    vt[6] = '{32'h000FC073, 3'b101, 32'h0000_0077, 64'h00000000_0000001F, 1'b0};
    vt[7] = '{32'h00000000, 3'b110, 32'h0000_0088, 64'h00000000_00000000, 1'b1};
    vt[8] = '{32'hFFFFFFFF, 3'b111, 32'h0000_0099, 64'h00000000_00000000, 1'b1};
    vt[9] = '{32'h7FF00093, 3'b000, 32'h1234_5678, 64'h00000000_000007FF, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_imm_sel = '0; in_tag = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_empty_reset("reset");

    // Back-to-back table vectors with out_ready high: each appears exactly one cycle later.
    for (int i = 0; i <= NV; i++) begin
      if (i < NV) cycle(1'b1, vt[i].instr, vt[i].sel, vt[i].tag, 1'b1, 1'b0, 1'b0);
      else        cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
      if (i > 0) check_vec($sformatf("vec%0d", i - 1), vt[i-1]);
    end

    // Back-pressure: tags 1,2 accepted, 3 refused until the skid entry moves.
    seen.delete();
    cycle(1'b1, vt[0].instr, vt[0].sel, 32'd1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vt[1].instr, vt[1].sel, 32'd2, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vt[2].instr, vt[2].sel, 32'd3, 1'b0, 1'b0, 1'b0);
    check("bp_full_ready", 64'(in_ready32), 64'(0));
    cycle(1'b1, vt[2].instr, vt[2].sel, 32'd3, 1'b0, 1'b0, 1'b0);
    check("bp_stall_tag", 64'(out_tag32), 64'(1));
    check("bp_stall_imm", out_imm64, vt[0].imm);
    cycle(1'b1, vt[2].instr, vt[2].sel, 32'd3, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, vt[2].instr, vt[2].sel, 32'd3, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("bp_count", 64'(seen.size()), 64'(3));
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) check($sformatf("bp_order%0d", i), 64'(seen[i]), 64'(i + 1));
    end

    // Flush while full, with a simultaneous input that must be discarded.
    cycle(1'b1, vt[3].instr, vt[3].sel, 32'h100, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vt[4].instr, vt[4].sel, 32'h101, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vt[5].instr, vt[5].sel, 32'hAA, 1'b0, 1'b1, 1'b0);
    seen.delete();
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_valid", 64'(out_valid32 | out_valid64), 64'(0));
    check("flush_ready", 64'(in_ready32 & in_ready64), 64'(1));
    repeat (3) cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("flush_no_output", 64'(seen.size()), 64'(0));

    // Reset mid-stream with flush also high, then a fresh entry with one-cycle latency.
    cycle(1'b1, vt[6].instr, vt[6].sel, 32'hB0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vt[1].instr, vt[1].sel, 32'hB1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, vt[2].instr, vt[2].sel, 32'hB2, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
    check_empty_reset("rst_mid");
    cycle(1'b1, vt[4].instr, vt[4].sel, vt[4].tag, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
    check("post_rst_valid", 64'(out_valid32), 64'(1));
    check_vec("post_rst", vt[4]);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 40) == 0),
            1'($urandom_range(0, 150) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
